// File: rtl/dot_sequencer_if.sv
// Command and instruction channels of the dot-product sequencer.
// DOT_SEQ_STRIDE_EN adds the cmd_stride field to the command channel.
interface dot_sequencer_if #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned LEN_WIDTH    = 8
);
  localparam int unsigned INS_WIDTH = OPCODE_WIDTH + 3 * ADDR_WIDTH;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_a_base;
  logic [ADDR_WIDTH-1:0] cmd_b_base;
  logic [ADDR_WIDTH-1:0] cmd_r_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
`ifdef DOT_SEQ_STRIDE_EN
  logic [ADDR_WIDTH-1:0] cmd_stride;
`endif
  logic                  ins_valid;
  logic                  ins_ready;
  logic [INS_WIDTH-1:0]  instruction;
  logic                  busy;
  logic                  done;

  // Job issuer / decoder side.
  modport master (
    output cmd_valid, cmd_a_base, cmd_b_base, cmd_r_addr, cmd_len,
`ifdef DOT_SEQ_STRIDE_EN
    output cmd_stride,
`endif
    output ins_ready,
    input  cmd_ready, ins_valid, instruction, busy, done
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_a_base, cmd_b_base, cmd_r_addr, cmd_len,
`ifdef DOT_SEQ_STRIDE_EN
    input  cmd_stride,
`endif
    input  ins_ready,
    output cmd_ready, ins_valid, instruction, busy, done
  );
endinterface

// File: rtl/dot_sequencer.sv
// Turns a dot-product job into one CLR plus len ACC instructions for the decoder.
// DOT_SEQ_STRIDE_EN: per-job address stride taken from cmd_stride (otherwise stride 1).
module dot_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned LEN_WIDTH    = 8
) (
  input  logic            clk,
  input  logic            rstn,
  dot_sequencer_if.slave  bus
);
  localparam int unsigned INS_WIDTH = OPCODE_WIDTH + 3 * ADDR_WIDTH;
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP = OPCODE_WIDTH'(3'b000);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACC = OPCODE_WIDTH'(3'b101);
  localparam logic [OPCODE_WIDTH-1:0] OP_CLR = OPCODE_WIDTH'(3'b110);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DONE} state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  i_q, i_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [ADDR_WIDTH-1:0] b_q, b_d;
  logic [ADDR_WIDTH-1:0] r_q, r_d;
  logic [ADDR_WIDTH-1:0] step;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  ins_valid_q, ins_valid_d;
  logic [INS_WIDTH-1:0]  instruction_q, instruction_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

`ifdef DOT_SEQ_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  assign step = stride_q;
`else
  assign step = ADDR_WIDTH'(1);
`endif

  // a_q/b_q hold the address of the element being issued, so a_base+i*S is a running sum.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    len_d   = len_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
`ifdef DOT_SEQ_STRIDE_EN
    stride_d = stride_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          a_d     = bus.cmd_a_base;
          b_d     = bus.cmd_b_base;
          r_d     = bus.cmd_r_addr;
          len_d   = bus.cmd_len;
          i_d     = '0;
`ifdef DOT_SEQ_STRIDE_EN
          stride_d = bus.cmd_stride;
`endif
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (bus.ins_ready) state_d = (len_q == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (bus.ins_ready) begin
          i_d = i_q + LEN_WIDTH'(1);
          a_d = a_q + step;
          b_d = b_q + step;
          if (i_q == len_q - LEN_WIDTH'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight from flops.
    cmd_ready_d   = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    ins_valid_d   = (state_d == CLEAR) || (state_d == ACCUM);
    instruction_d = {{(3 * ADDR_WIDTH){1'b0}}, OP_NOP};
    if (state_d == CLEAR)      instruction_d = {a_d, b_d, r_d, OP_CLR};
    else if (state_d == ACCUM) instruction_d = {a_d, b_d, r_d, OP_ACC};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      i_q           <= '0;
      len_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      r_q           <= '0;
`ifdef DOT_SEQ_STRIDE_EN
      stride_q      <= '0;
`endif
      cmd_ready_q   <= 1'b1;
      ins_valid_q   <= 1'b0;
      instruction_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      len_q         <= len_d;
      a_q           <= a_d;
      b_q           <= b_d;
      r_q           <= r_d;
`ifdef DOT_SEQ_STRIDE_EN
      stride_q      <= stride_d;
`endif
      cmd_ready_q   <= cmd_ready_d;
      ins_valid_q   <= ins_valid_d;
      instruction_q <= instruction_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.ins_valid   = ins_valid_q;
  assign bus.instruction = instruction_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_dot_sequencer.sv
// Bench for dot_sequencer: per-cycle comparison against a job-level instruction queue model,
// directed corner jobs with literal expectations, then randomized jobs and ready patterns.
module tb_dot_sequencer;
  localparam int unsigned AW = 10;
  localparam int unsigned OW = 3;
  localparam int unsigned LW = 8;
  localparam int unsigned IW = OW + 3 * AW;
  localparam int OPC_ACC = 5;
  localparam int OPC_CLR = 6;

  logic clk;
  logic rstn;

  dot_sequencer_if #(.ADDR_WIDTH(AW), .OPCODE_WIDTH(OW), .LEN_WIDTH(LW)) bus ();

  dot_sequencer #(.ADDR_WIDTH(AW), .OPCODE_WIDTH(OW), .LEN_WIDTH(LW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rst_applied = 1'b0;
  bit chk_en = 1'b0;
  int done_cnt = 0;
`ifdef DOT_SEQ_STRIDE_EN
  int stride_val = 1;
`endif

  // Model state: instructions still owed for the current job, and when things should happen.
  logic [IW-1:0] exp_q[$];
  bit            m_busy = 1'b0;
  int            m_start = 0;
  int            m_done_cyc = -1;

  logic [IW-1:0] log_q[$];
  int            acc_cyc_q[$];
  int            done_cyc_q[$];

  bit            exp_ready, exp_done, exp_iv;
  logic [IW-1:0] exp_ins;

  function automatic logic [IW-1:0] mk_ins(int a, int b, int r, int op);
    logic [AW-1:0] av, bv, rv;
    logic [OW-1:0] ov;
    av = AW'(a); bv = AW'(b); rv = AW'(r); ov = OW'(op);
    return {av, bv, rv, ov};
  endfunction

  function automatic int f_a(logic [IW-1:0] x);  return int'(x[IW-1 -: AW]);      endfunction
  function automatic int f_b(logic [IW-1:0] x);  return int'(x[IW-1-AW -: AW]);   endfunction
  function automatic int f_op(logic [IW-1:0] x); return int'(x[OW-1:0]);          endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_log(int idx, int op, int a, int b);
    if (idx < log_q.size()) begin
      check($sformatf("log[%0d].op", idx), 64'(f_op(log_q[idx])), 64'(op));
      check($sformatf("log[%0d].a", idx),  64'(f_a(log_q[idx])),  64'(a));
      check($sformatf("log[%0d].b", idx),  64'(f_b(log_q[idx])),  64'(b));
    end else begin
      check($sformatf("log[%0d].present", idx), 64'(log_q.size()), 64'(idx + 1));
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_applied <= !rstn;
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_applied) begin
      chk_en = 1'b1;
      check("rst.cmd_ready",   64'(bus.cmd_ready),   64'(1));
      check("rst.busy",        64'(bus.busy),        64'(0));
      check("rst.done",        64'(bus.done),        64'(0));
      check("rst.ins_valid",   64'(bus.ins_valid),   64'(0));
      check("rst.instruction", 64'(bus.instruction), 64'(0));
      exp_q.delete();
      m_busy = 1'b0;
      m_done_cyc = -1;
    end else if (chk_en) begin
      exp_ready = !m_busy;
      exp_done  = (cyc == m_done_cyc);
      exp_iv    = m_busy && (cyc >= m_start) && (exp_q.size() > 0);
      exp_ins   = exp_iv ? exp_q[0] : '0;
      check("cmd_ready",   64'(bus.cmd_ready),   64'(exp_ready));
      check("busy",        64'(bus.busy),        64'(!exp_ready));
      check("done",        64'(bus.done),        64'(exp_done));
      check("ins_valid",   64'(bus.ins_valid),   64'(exp_iv));
      check("instruction", 64'(bus.instruction), 64'(exp_ins));

      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc_q.push_back(cyc);
      end
      if (bus.ins_valid === 1'b1 && bus.ins_ready) log_q.push_back(bus.instruction);
      if (exp_iv && bus.ins_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_done_cyc = cyc + 1;
      end
      if (exp_done) m_busy = 1'b0;
      if (bus.cmd_valid && exp_ready) begin
        int a, b, r, len, s;
        a = int'(bus.cmd_a_base);
        b = int'(bus.cmd_b_base);
        r = int'(bus.cmd_r_addr);
        len = int'(bus.cmd_len);
`ifdef DOT_SEQ_STRIDE_EN
        s = int'(bus.cmd_stride);
`else
        s = 1;
`endif
        exp_q.push_back(mk_ins(a, b, r, OPC_CLR));
        for (int k = 0; k < len; k++)
          exp_q.push_back(mk_ins((a + k * s) % 1024, (b + k * s) % 1024, r, OPC_ACC));
        m_busy = 1'b1;
        m_start = cyc + 1;
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    log_q.delete();
    acc_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  // Called just after a rising edge; the command is accepted at the next edge.
  task automatic start_job(int a, int b, int r, int len, bit hold);
    bus.cmd_a_base = AW'(a);
    bus.cmd_b_base = AW'(b);
    bus.cmd_r_addr = AW'(r);
    bus.cmd_len    = LW'(len);
`ifdef DOT_SEQ_STRIDE_EN
    bus.cmd_stride = AW'(stride_val);
`endif
    bus.cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low for the 3 cycles of the first ACC.
  task automatic wait_done(int mode);
    int t;
    bit seen;
    t = 1;
    seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      case (mode)
        0:       bus.ins_ready = 1'b1;
        1:       bus.ins_ready = ($urandom_range(0, 2) != 0);
        default: bus.ins_ready = !(t >= 2 && t <= 4);
      endcase
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      t++;
    end
    check("done_seen", 64'(seen), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int snap;
    rstn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a_base = '0;
    bus.cmd_b_base = '0;
    bus.cmd_r_addr = '0;
    bus.cmd_len = '0;
`ifdef DOT_SEQ_STRIDE_EN
    bus.cmd_stride = '0;
`endif
    bus.ins_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

`ifdef DOT_SEQ_STRIDE_EN
    stride_val = 1;
`endif
    // Basic job with ready tied high.
    clear_logs();
    start_job('h010, 'h020, 'h030, 3, 1'b0);
    wait_done(0);
    check("t1.count", 64'(log_q.size()), 64'(4));
    check("t1.r", 64'(int'(log_q[0][OW +: AW])), 64'('h030));
    check_log(0, OPC_CLR, 'h010, 'h020);
    check_log(1, OPC_ACC, 'h010, 'h020);
    check_log(2, OPC_ACC, 'h011, 'h021);
    check_log(3, OPC_ACC, 'h012, 'h022);
    check("t1.latency", 64'(done_cyc_q[0] - acc_cyc_q[0]), 64'(5));

    // Empty job: CLR only.
    clear_logs();
    start_job('h0AA, 'h0BB, 'h0CC, 0, 1'b0);
    wait_done(0);
    check("t2.count", 64'(log_q.size()), 64'(1));
    check_log(0, OPC_CLR, 'h0AA, 'h0BB);
    check("t2.latency", 64'(done_cyc_q[0] - acc_cyc_q[0]), 64'(2));

    // Stall during the first ACC.
    clear_logs();
    start_job('h100, 'h200, 'h300, 2, 1'b0);
    wait_done(2);
    check("t3.count", 64'(log_q.size()), 64'(3));
    check_log(1, OPC_ACC, 'h100, 'h200);
    check_log(2, OPC_ACC, 'h101, 'h201);
    check("t3.latency", 64'(done_cyc_q[0] - acc_cyc_q[0]), 64'(7));

    // Address wrap.
    clear_logs();
`ifdef DOT_SEQ_STRIDE_EN
    stride_val = 2;
    start_job('h3FE, 'h100, 'h055, 4, 1'b0);
    wait_done(0);
    check_log(1, OPC_ACC, 'h3FE, 'h100);
    check_log(2, OPC_ACC, 'h000, 'h102);
    check_log(3, OPC_ACC, 'h002, 'h104);
    check_log(4, OPC_ACC, 'h004, 'h106);
    stride_val = 1;
`else
    start_job('h3FE, 'h100, 'h055, 4, 1'b0);
    wait_done(0);
    check_log(1, OPC_ACC, 'h3FE, 'h100);
    check_log(2, OPC_ACC, 'h3FF, 'h101);
    check_log(3, OPC_ACC, 'h000, 'h102);
    check_log(4, OPC_ACC, 'h001, 'h103);
`endif

    // cmd_valid held through a job: the next accept comes the cycle after done.
    clear_logs();
    start_job('h001, 'h002, 'h003, 2, 1'b1);
    wait_done(0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_done(0);
    check("t5.accepts", 64'(acc_cyc_q.size()), 64'(2));
    check("t5.first_latency", 64'(done_cyc_q[0] - acc_cyc_q[0]), 64'(4));
    if (acc_cyc_q.size() == 2)
      check("t5.reaccept", 64'(acc_cyc_q[1] - done_cyc_q[0]), 64'(1));

    // Reset in the middle of ACCUM abandons the job.
    clear_logs();
    snap = done_cnt;
    start_job('h040, 'h050, 'h060, 6, 1'b0);
    bus.ins_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("t6.cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("t6.busy",      64'(bus.busy),      64'(0));
    check("t6.ins_valid", 64'(bus.ins_valid), 64'(0));
    check("t6.instr",     64'(bus.instruction), 64'(0));
    repeat (10) @(posedge clk);
    #1;
    check("t6.no_done", 64'(done_cnt - snap), 64'(0));

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      int len;
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 6));
`ifdef DOT_SEQ_STRIDE_EN
      stride_val = int'($urandom_range(0, 1023));
`endif
      start_job(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 1023)), len, 1'b0);
      wait_done(($urandom_range(0, 3) == 0) ? 0 : 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dot_sequencer.md
DOT_SEQUENCER -- requirements
Module: dot_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, datapath BRAM address width.
REQ-002 The block SHALL have parameter OPCODE_WIDTH, default 3, instruction opcode width.
REQ-003 The block SHALL have parameter LEN_WIDTH, default 8, element-count width.
REQ-004 The block SHALL have ports: clk input 1 clock; rstn input 1 reset, synchronous, active-low.
REQ-005 The block SHALL have ports: cmd_valid input 1 job request; cmd_ready output 1 job accept.
REQ-006 The block SHALL have ports: cmd_a_base, cmd_b_base, cmd_r_addr input ADDR_WIDTH each; cmd_len input LEN_WIDTH.
REQ-007 The block SHALL have ports: ins_valid output 1; ins_ready input 1; instruction output OPCODE_WIDTH+3*ADDR_WIDTH to decoder.
REQ-008 The block SHALL have ports: busy output 1 job in progress; done output 1 single-cycle job completion pulse.

Function
REQ-009 The instruction SHALL be packed {a_addr, b_addr, r_addr, opcode}, with opcode in the LSBs; opcodes are NOP=000, ACC=101, CLR=110.
REQ-010 The FSM SHALL use states IDLE, CLEAR, ACCUM and DONE; cmd_ready=1 only in IDLE.
REQ-011 On cmd_valid&&cmd_ready, the block SHALL latch all cmd_* fields, zero the element index i and enter CLEAR.
REQ-012 In CLEAR the block SHALL drive ins_valid=1 and instruction {a_base, b_base, r_addr, CLR}; on ins_ready it enters ACCUM, or DONE if len==0.
REQ-013 In ACCUM the block SHALL drive {a_base+i*S, b_base+i*S, r_addr, ACC}; on ins_ready it increments i, and when i==len-1 it enters DONE.
REQ-014 Address sums SHALL wrap modulo 2^ADDR_WIDTH; S=1 unless REQ-022 applies.
REQ-015 While ins_valid=1 and ins_ready=0, instruction SHALL hold stable; ins_valid SHALL never drop without a handshake.
REQ-016 In DONE the block SHALL drive done=1 for exactly one cycle with ins_valid=0, then return to IDLE.
REQ-017 In IDLE and DONE, instruction SHALL be all zeros (NOP) and ins_valid=0.
REQ-018 busy SHALL equal (state!=IDLE); a job SHALL issue exactly len+1 instructions.
REQ-019 The first instruction SHALL be presented the cycle after accept; with ins_ready tied high, done SHALL assert len+2 cycles after accept.
REQ-020 cmd_* SHALL be ignored while busy, and the pending cmd_valid SHALL be accepted only on return to IDLE.

Reset
REQ-021 rstn=0 at a clock edge SHALL force IDLE, i=0 and all latched fields to 0; the outputs SHALL then be cmd_ready=1, ins_valid=0, instruction=0, busy=0, done=0. A mid-job reset SHALL abandon the job with no done pulse.

Configuration
REQ-022 With DOT_SEQ_STRIDE_EN defined, the block SHALL add input cmd_stride (ADDR_WIDTH), latched at accept, with S=cmd_stride and wrap per REQ-014. Without the macro, the port SHALL be absent and S=1.

Verification
REQ-023 With a_base=0x010, b_base=0x020, r=0x030, len=3 and ins_ready=1, the bench SHALL see CLR(10,20,30) followed by ACC (10,20),(11,21),(12,22), then done at accept+5.
REQ-024 With len=0, the bench SHALL see a single CLR, then done at accept+2 with no ACC issued.
REQ-025 With len=2 and ins_ready low for 3 cycles during the first ACC, the instruction SHALL stay stable, ins_valid SHALL stay high and no ACC SHALL be skipped or duplicated.
REQ-026 With a_base=0x3FE and len=4, the a-addresses SHALL be 3FE, 3FF, 000, 001; with DOT_SEQ_STRIDE_EN defined and stride=2, they SHALL be 3FE, 000, 002, 004.
REQ-027 cmd_valid held high during a job SHALL be accepted only the cycle after done; rstn low mid-ACCUM SHALL give IDLE, all outputs per REQ-021 and no done.
